// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0] DEF_PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Instruction words are 2 PC units wide, so targets are forced even.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux (redirect > advance > hold).
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;

    // Next-PC selection; the sum wraps naturally at 16 bits.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect) begin
            pc_next_s = align_pc(redirect_pc);
        end else if (advance) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: IDLE/RUN/HALT control, PC sequencing and the IF/ID output register.
// Optional accepted-instruction counter enabled by defining FETCH_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               halt_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] out_instr_o,
`ifdef FETCH_CNT_EN
    output logic [PC_W-1:0]    out_pc_o,
    output logic [15:0]        fetch_cnt_o
`else
    output logic [PC_W-1:0]    out_pc_o
`endif
);

    state_t             state_r;
    logic               out_valid_r;
    logic [INSTR_W-1:0] out_instr_r;
    logic [PC_W-1:0]    out_pc_r;
    logic [PC_W-1:0]    pc_s;
    logic               xfer_s;
    logic               fetch_s;

    assign xfer_s = out_valid_r & out_ready_i;

    // A fetch needs RUN, no redirect/halt this cycle, and room in IF/ID.
    assign fetch_s = (state_r == RUN) & ~redirect_i & ~halt_i & (~out_valid_r | out_ready_i);

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .advance     (fetch_s),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .pc          (pc_s)
    );

    // Control state machine; redirect keeps IDLE in IDLE and wins over halt in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i && !redirect_i) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (halt_i && !redirect_i) begin
                        state_r <= HALT;
                    end
                end
                HALT: begin
                    if (redirect_i) begin
                        state_r <= RUN;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // IF/ID register: redirect flushes, fetch loads, a transfer without refill drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_pc_r    <= 16'h0000;
        end else if (redirect_i) begin
            out_valid_r <= 1'b0;
        end else if (fetch_s) begin
            out_valid_r <= 1'b1;
            out_instr_r <= instr_i;
            out_pc_r    <= pc_s;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt_r;

    // Count accepted instructions; a flushed one is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= 16'h0000;
        end else if (xfer_s && !redirect_i) begin
            fetch_cnt_r <= fetch_cnt_r + 16'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_r;
`endif

    assign pc_o        = pc_s;
    assign out_valid_o = out_valid_r;
    assign out_instr_o = out_instr_r;
    assign out_pc_o    = out_pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random traffic.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        halt_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] pc_o;
    logic [31:0] instr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [15:0] out_pc_o;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt_o;
`endif

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:32767];

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
    } item_t;

    item_t       exp_q[$];
    logic [15:0] m_pc   = 16'h0000;
    logic        m_pend = 1'b0;
    int          m_mode = 0;
    logic [15:0] m_cnt  = 16'h0000;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
`ifdef FETCH_CNT_EN
        .out_pc_o      (out_pc_o),
        .fetch_cnt_o   (fetch_cnt_o)
`else
        .out_pc_o      (out_pc_o)
`endif
    );

    always #5 clk = ~clk;

    assign instr_i = mem[pc_o[15:1]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks mode, PC and the single pending IF/ID slot.
    initial forever begin
        logic xfer, fetch;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_pc = 16'h0000; m_pend = 1'b0; m_cnt = 16'h0000;
            exp_q.delete();
        end else if (redirect_i) begin
            if (m_pend) void'(exp_q.pop_back());
            m_pend = 1'b0;
            m_pc   = {redirect_pc_i[15:1], 1'b0};
            if (m_mode == 2) m_mode = 1;
        end else begin
            xfer  = m_pend && out_ready_i;
            fetch = (m_mode == 1) && !halt_i && (!m_pend || out_ready_i);
            if (xfer) m_cnt = m_cnt + 16'd1;
            if (fetch) begin
                exp_q.push_back('{instr: mem[m_pc / 2], pc: m_pc});
                m_pend = 1'b1;
                m_pc   = m_pc + 16'd2;
            end else if (xfer) begin
                m_pend = 1'b0;
            end
            if (m_mode == 0 && start_i) m_mode = 1;
            else if (m_mode == 1 && halt_i) m_mode = 2;
        end
    end

    // Monitor: checks each accepted instruction and the visible PC/valid state.
    initial forever begin
        item_t e;
        @(negedge clk);
        if (!rst && out_valid_o && out_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {31'h0, out_valid_o}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", out_instr_o, e.instr);
                chk("sb_pc", {16'h0, out_pc_o}, {16'h0, e.pc});
            end
        end
        chk("pc_o", {16'h0, pc_o}, {16'h0, m_pc});
        chk("pc_o_even", {31'h0, pc_o[0]}, 32'h0);
        chk("valid", {31'h0, out_valid_o}, {31'h0, m_pend});
`ifdef FETCH_CNT_EN
        chk("fetch_cnt", {16'h0, fetch_cnt_o}, {16'h0, m_cnt});
`endif
    end

    task automatic chk_reset();
        chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("rst_instr", out_instr_o, 32'h0);
        chk("rst_outpc", {16'h0, out_pc_o}, 32'h0);
        chk("rst_pc", {16'h0, pc_o}, 32'h0);
`ifdef FETCH_CNT_EN
        chk("rst_cnt", {16'h0, fetch_cnt_o}, 32'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = $urandom;
        mem[0] = 32'h411F0000;
        mem[1] = 32'h422F0001;
        rst = 1'b1; start_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 16'h0000; out_ready_i = 1'b1;
        cyc(); cyc();
        chk_reset();

        // Basic fetch of two words.
        rst = 1'b0; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        chk("w0_instr", out_instr_o, 32'h411F0000);
        chk("w0_pc", {16'h0, out_pc_o}, 32'h0);
        cyc();
        chk("w1_instr", out_instr_o, 32'h422F0001);
        chk("w1_pc", {16'h0, out_pc_o}, 32'h2);
        chk("w1_pco", {16'h0, pc_o}, 32'h4);

        // Stall three cycles, then release.
        out_ready_i = 1'b0;
        repeat (3) cyc();
        chk("stall_pc", {16'h0, out_pc_o}, 32'h2);
        chk("stall_instr", out_instr_o, 32'h422F0001);
        chk("stall_pco", {16'h0, pc_o}, 32'h4);
        out_ready_i = 1'b1;
        cyc();
        chk("release_pc", {16'h0, out_pc_o}, 32'h4);

        // Redirect while stalled.
        out_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 16'h0011;
        cyc();
        chk("redir_valid", {31'h0, out_valid_o}, 32'h0);
        chk("redir_pco", {16'h0, pc_o}, 32'h10);
        redirect_i = 1'b0; out_ready_i = 1'b1;
        cyc();
        chk("redir_outpc", {16'h0, out_pc_o}, 32'h10);

        // Wrap at the top of the address space.
        redirect_i = 1'b1; redirect_pc_i = 16'hFFFE;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("wrap_a", {16'h0, out_pc_o}, 32'hFFFE);
        cyc();
        chk("wrap_b", {16'h0, out_pc_o}, 32'h0);

        // Halt together with redirect stays in RUN.
        halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h0100;
        cyc();
        halt_i = 1'b0; redirect_i = 1'b0;
        cyc();
        chk("hr_valid", {31'h0, out_valid_o}, 32'h1);
        chk("hr_pc", {16'h0, out_pc_o}, 32'h100);
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        chk("halt_drain", {31'h0, out_valid_o}, 32'h0);
        cyc();
        chk("halt_idle", {31'h0, out_valid_o}, 32'h0);
        chk("halt_pco", {16'h0, pc_o}, 32'h102);
        redirect_i = 1'b1; redirect_pc_i = 16'h0200;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("resume_valid", {31'h0, out_valid_o}, 32'h1);
        chk("resume_pc", {16'h0, out_pc_o}, 32'h200);

        // Five transfers plus one flushed instruction, then reset mid-stall.
        rst = 1'b1;
        cyc();
        rst = 1'b0; start_i = 1'b1; out_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (6) cyc();
        redirect_i = 1'b1; redirect_pc_i = 16'h0040;
        cyc();
`ifdef FETCH_CNT_EN
        chk("cnt_five", {16'h0, fetch_cnt_o}, 32'd5);
`endif
        chk("flush_valid", {31'h0, out_valid_o}, 32'h0);
        redirect_i = 1'b0; out_ready_i = 1'b0;
        cyc(); cyc();
        rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h1234;
        cyc();
        chk_reset();
        rst = 1'b0; redirect_i = 1'b0;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 299) == 0);
            start_i       = ($urandom_range(0, 7) == 0);
            halt_i        = ($urandom_range(0, 19) == 0);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = 16'($urandom);
            out_ready_i   = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst = 1'b0; start_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 Parameter PC_STEP, default 16'd2: PC increment per fetched instruction, one 32-bit word per 2 PC units.
REQ-004 Ports SHALL be exactly:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  leave IDLE and begin fetching
- halt_i  in  1  stop issuing new fetches
- redirect_i  in  1  load a new PC and flush output
- redirect_pc_i  in  16  redirect target
- pc_o  out  16  address to instruction memory
- instr_i  in  32  combinational instruction-memory data for pc_o, same cycle
- out_valid_o  out  1  IF/ID register holds an instruction
- out_ready_i  in  1  downstream accepts this cycle
- out_instr_o  out  32  fetched instruction
- out_pc_o  out  16  PC of out_instr_o
- fetch_cnt_o  out  16  accepted-instruction count; present only per REQ-020

Function
REQ-005 States SHALL be IDLE, RUN and HALT.
REQ-006 Transitions SHALL be:
- IDLE->RUN on start_i.
- RUN->HALT on halt_i.
- HALT->RUN on redirect_i.
- Any other condition holds the current state.
REQ-007 pc_o SHALL equal the PC register combinationally; the register changes only on clock edges.
REQ-008 A transfer SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-009 In RUN without redirect_i, when out_valid_o==0 or out_ready_i==1:
- IF/ID loads out_instr_o<=instr_i and out_pc_o<=pc.
- out_valid_o<=1.
- pc<=pc+PC_STEP, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- Latency is one clock from pc_o to out_valid_o.
REQ-010 Stall: when out_valid_o==1 and out_ready_i==0, pc, out_instr_o, out_pc_o and out_valid_o SHALL hold unchanged.
REQ-011 In IDLE or HALT, no new fetch SHALL occur:
- A pending output stays valid until transferred.
- After the transfer, out_valid_o clears.
REQ-012 Redirect SHALL have highest priority in every state:
- pc<={redirect_pc_i[15:1],1'b0}.
- out_valid_o<=0, discarding any pending output even if out_ready_i==1 that cycle.
- No fetch occurs that cycle.
REQ-013 Redirect in IDLE SHALL load pc and remain in IDLE.
REQ-014 Simultaneous halt_i and redirect_i in RUN SHALL redirect and remain in RUN; halt_i is ignored that cycle.
REQ-015 halt_i in RUN SHALL suppress the fetch in the same cycle; the state is HALT next cycle.
REQ-016 start_i in RUN or HALT SHALL be ignored.

Reset
REQ-017 On rst, all of the following SHALL hold regardless of other inputs, including mid-stall or mid-redirect:
- state=IDLE
- pc=RESET_PC
- out_valid_o=0
- out_instr_o=32'h0
- out_pc_o=16'h0
- fetch_cnt_o=0
REQ-018 Reset SHALL take effect on the first clk edge with rst==1, and no output SHALL depend on rst combinationally.

Configuration
REQ-019 The block SHALL support the macro FETCH_CNT_EN.
REQ-020 With FETCH_CNT_EN defined:
- fetch_cnt_o exists.
- It increments by 1 on each transfer, wrapping 16'hFFFF->0.
- A redirect does not count a discarded instruction.
REQ-021 Without FETCH_CNT_EN, the fetch_cnt_o port and counter logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 Package fetch_pkg SHALL hold:
- state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2)
- PC width 16 and instruction width 32 constants
- default RESET_PC and PC_STEP
REQ-023 The PC register and next-PC mux SHALL form sub-module fetch_pc_reg; state machine and IF/ID register stay in fetch_stage.

Verification
REQ-024 Reset then start_i, memory word0=32'h411F0000, word1=32'h422F0001, out_ready_i=1 -> cycle+1: out_instr_o=32'h411F0000, out_pc_o=0; cycle+2: 32'h422F0001, out_pc_o=2; pc_o=4.
REQ-025 With out_valid_o=1 and out_pc_o=2, hold out_ready_i=0 for 3 cycles -> outputs and pc_o=4 unchanged; release -> next out_pc_o=4, no instruction lost or duplicated.
REQ-026 redirect_i with redirect_pc_i=16'h0011 while stalled -> next cycle out_valid_o=0, pc_o=16'h0010; following cycle out_pc_o=16'h0010.
REQ-027 redirect_pc_i=16'hFFFE in RUN -> fetches at 16'hFFFE then 16'h0000 (wrap).
REQ-028 halt_i with halt_i and redirect_i together -> state stays RUN at the target; halt_i alone -> fetching stops, pending output drains, out_valid_o=0; redirect from HALT resumes RUN.
REQ-029 With FETCH_CNT_EN, 5 transfers plus 1 flushed instruction -> fetch_cnt_o=5; rst asserted mid-stall -> all REQ-017 values on the next edge.
